arbitro_memoria_datos: RTL and testbench
========================================

Name: arbitro_memoria_datos

Overview:
- Arbitrates the single-port, word-addressed data memory between two requesters: the core load/store path (port C) and the program-loader/debug port (port D).
- Round-robin arbitration, optional locked bursts, and a registered one-cycle read response.
- Drives a stall to the core while its access is pending.
- Sits in top between the ALU/RS2 load-store path and DataMemory.

Parameters:
- ADDR_W, 5, word-address width (32-word memory)
- DATA_W, 32, data width
- MAX_BURST, 4, maximum consecutive locked beats for one owner; legal range 1..15

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- c_req  in  1  core access request
- c_we  in  1  core write (1) / read (0)
- c_lock  in  1  core requests burst ownership
- c_addr  in  ADDR_W  core word address
- c_wdata  in  DATA_W  core write data
- c_gnt  out  1  core beat accepted this cycle
- c_rvalid  out  1  core read data valid
- c_rdata  out  DATA_W  core read data
- c_stall  out  1  c_req & ~c_gnt, freezes the core PC
- d_req, d_we, d_lock, d_addr, d_wdata, d_gnt, d_rvalid, d_rdata: same as the c_* ports, for port D
- mem_we  out  1  memory write enable
- mem_re  out  1  memory read enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data (combinational)

Behaviour:
- **Reset (reset_n=0, asynchronous):**
  - state=IDLE, last_owner=D (so C wins the first tie), beat_cnt=0.
  - c_rvalid=d_rvalid=0, c_rdata=d_rdata=0.
  - Any pending read response is discarded.
  - c_gnt, d_gnt, mem_we, mem_re are 0 while reset is held; mem_addr and mem_wdata are 0.
- **Beat:** a transfer occurs in any cycle where x_gnt=1. The gnt/mem_* signals are combinational from state, req and last_owner.
  - At most one gnt per cycle.
  - No gnt means mem_we=mem_re=0 and mem_addr=mem_wdata=0.
- **Write beat:** mem_we=1, with mem_addr/mem_wdata taken from the owner. The write is committed by memory on that clock edge.
- **Read beat:** mem_re=1. mem_rdata is registered into x_rdata and x_rvalid=1 on the following cycle, for exactly one cycle.
  - x_rdata holds its value until the next read for that port.
  - A back-to-back read gives one rvalid per cycle.
- **IDLE:**
  - One requester only: it is granted.
  - Both requesting: the port not equal to last_owner is granted.
  - After a grant, last_owner is set to the granted port.
  - If the granted port also has lock=1 (and MAX_BURST>1): next state is OWN_x with beat_cnt=1. Otherwise stay in IDLE.
- **OWN_C / OWN_D:**
  - Only the owner can be granted; the other port is held off, with its stall asserted.
  - Owner beat with lock=1: beat_cnt increments. When beat_cnt reaches MAX_BURST, return to IDLE.
  - Owner beat with lock=0: this is the final beat; return to IDLE.
  - Owner req=0: no grant that cycle (one bubble), then return to IDLE.
- **Simultaneous events:**
  - A read response for the previous beat and a new grant to the same or the other port in the same cycle are both legal.
  - rvalid is routed to whichever port issued the read.
- **Reset mid-burst:** the burst is aborted and no rvalid is produced afterwards.
- **Addresses:** passed unmodified; out-of-range addresses are not possible at ADDR_W=5.

Decomposition:
- Shared package holds:
  - the state encoding (IDLE=2'b00, OWN_C=2'b01, OWN_D=2'b10)
  - the port-id constants (PORT_C=1'b0, PORT_D=1'b1)
  - the ADDR_W/DATA_W defaults shared with DataMemory.
- One sub-module: rr_selector_2 (combinational two-way round-robin pick from req[1:0] and last_owner, returning a one-hot grant). The FSM, burst counter and response register stay in the top of the block.

Test Plan:
- Reset → c_gnt=d_gnt=0, mem_we=0, rvalid=0, rdata=0.
  - Then c_req=1, c_we=1, addr=3, wdata=0xDEADBEEF → c_gnt=1, mem_we=1 and mem_addr=3 in the same cycle.
- C reads addr 3 with mem_rdata=0xDEADBEEF → c_rvalid=1 and c_rdata=0xDEADBEEF exactly one cycle later; c_stall=0 throughout.
- c_req=d_req=1 held for 4 cycles, no lock → grants alternate C,D,C,D; c_stall=1 on the D cycles.
- d_req=d_lock=1 for 6 beats with c_req=1 and MAX_BURST=4 → D gets 4 consecutive beats, then C is granted; c_stall=1 for 4 cycles.
- D locked, drops req after beat 2 → one cycle with no grant, then C is granted.
- reset_n pulsed low during a read beat → no rvalid afterwards; state=IDLE, and on the next tie C wins.

Source files
------------

// File: rtl/arbitro_memoria_datos_pkg.sv
// Shared definitions for the data-memory arbiter: state encoding, port ids
// and the address/data width defaults shared with DataMemory.
package arbitro_memoria_datos_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 32;

  localparam logic PORT_C = 1'b0;
  localparam logic PORT_D = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    OWN_C = 2'b01,
    OWN_D = 2'b10
  } state_t;

endpackage

// File: rtl/arbitro_memoria_datos_rr.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the port
// that was not the last owner. Grant is one-hot (bit 0 = C, bit 1 = D).
module rr_selector_2
  import arbitro_memoria_datos_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (req == 2'b11) begin
      gnt = (last_owner == PORT_D) ? 2'b01 : 2'b10;
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/arbitro_memoria_datos.sv
// Arbiter for the single-port data memory between the core (C) and the
// loader/debug port (D): round-robin, locked bursts, registered read data.
module arbitro_memoria_datos
  import arbitro_memoria_datos_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              c_req,
  input  logic              c_we,
  input  logic              c_lock,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  output logic              c_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic              d_lock,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        dbg_state
);

  // Handshake: a beat happens in the cycle x_gnt=1; the requester keeps
  // req/we/lock/addr/wdata steady until then, and a read beat returns its
  // data with x_rvalid=1 for exactly the following cycle.

  localparam logic [3:0] MAX_B    = 4'(MAX_BURST);
  localparam bit         BURST_EN = (MAX_BURST > 1);

  state_t     state, state_n;
  logic       last_owner, last_owner_n;
  logic [3:0] beat_cnt, beat_cnt_n;
  logic [3:0] cnt_inc;
  logic [1:0] rr_gnt;

  rr_selector_2 u_rr (
    .req       ({d_req, c_req}),
    .last_owner(last_owner),
    .gnt       (rr_gnt)
  );

  assign cnt_inc = beat_cnt + 4'd1;

  always_comb begin
    state_n      = state;
    last_owner_n = last_owner;
    beat_cnt_n   = beat_cnt;
    c_gnt        = 1'b0;
    d_gnt        = 1'b0;
    if (reset_n) begin
      case (state)
        IDLE: begin
          c_gnt = rr_gnt[0];
          d_gnt = rr_gnt[1];
          if (rr_gnt[0]) begin
            last_owner_n = PORT_C;
            if (c_lock && BURST_EN) begin
              state_n    = OWN_C;
              beat_cnt_n = 4'd1;
            end
          end else if (rr_gnt[1]) begin
            last_owner_n = PORT_D;
            if (d_lock && BURST_EN) begin
              state_n    = OWN_D;
              beat_cnt_n = 4'd1;
            end
          end
        end
        OWN_C: begin
          c_gnt = c_req;
          // A dropped request costs one bubble cycle before re-arbitration.
          if (!c_req || !c_lock || cnt_inc == MAX_B) begin
            state_n    = IDLE;
            beat_cnt_n = 4'd0;
          end else begin
            beat_cnt_n = cnt_inc;
          end
        end
        OWN_D: begin
          d_gnt = d_req;
          if (!d_req || !d_lock || cnt_inc == MAX_B) begin
            state_n    = IDLE;
            beat_cnt_n = 4'd0;
          end else begin
            beat_cnt_n = cnt_inc;
          end
        end
        default: begin
          state_n    = IDLE;
          beat_cnt_n = 4'd0;
        end
      endcase
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (c_gnt) begin
      mem_we    = c_we;
      mem_re    = ~c_we;
      mem_addr  = c_addr;
      mem_wdata = c_wdata;
    end else if (d_gnt) begin
      mem_we    = d_we;
      mem_re    = ~d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      last_owner <= PORT_D;
      beat_cnt   <= 4'd0;
    end else begin
      state      <= state_n;
      last_owner <= last_owner_n;
      beat_cnt   <= beat_cnt_n;
    end
  end

  // Read data is captured per port so each keeps its last value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      c_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      c_rdata  <= '0;
      d_rdata  <= '0;
    end else begin
      c_rvalid <= c_gnt & ~c_we;
      d_rvalid <= d_gnt & ~d_we;
      if (c_gnt && !c_we) c_rdata <= mem_rdata;
      if (d_gnt && !d_we) d_rdata <= mem_rdata;
    end
  end

  assign c_stall   = c_req & ~c_gnt;
  assign dbg_state = state;

endmodule

// File: tb/tb_arbitro_memoria_datos.sv
// Bench for arbitro_memoria_datos: directed literal checks from the test plan
// plus randomized traffic compared every cycle against a behavioural model.
module tb_arbitro_memoria_datos;
  import arbitro_memoria_datos_pkg::*;

  localparam int AW        = 5;
  localparam int DW        = 32;
  localparam int MAX_BURST = 4;

  logic          clk;
  logic          reset_n;
  logic          c_req, c_we, c_lock, d_req, d_we, d_lock;
  logic [AW-1:0] c_addr, d_addr;
  logic [DW-1:0] c_wdata, d_wdata;
  logic          c_gnt, c_rvalid, c_stall, d_gnt, d_rvalid;
  logic [DW-1:0] c_rdata, d_rdata;
  logic          mem_we, mem_re;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [1:0]    dbg_state;

  arbitro_memoria_datos #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .reset_n(reset_n),
    .c_req(c_req), .c_we(c_we), .c_lock(c_lock), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata), .c_stall(c_stall),
    .d_req(d_req), .d_we(d_we), .d_lock(d_lock), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DataMemory stand-in, driven only by the DUT's memory port.
  logic [DW-1:0] dm [32];
  always @(posedge clk) if (mem_we) dm[mem_addr] <= mem_wdata;
  assign mem_rdata = dm[mem_addr];

  // ---------------- counters / check ----------------
  int n_vec = 0;
  int n_err = 0;
  bit run   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // owner: 0 = nobody holds a burst, 1 = C, 2 = D; last: 0 = C, 1 = D.
  int            m_owner, m_beats, m_last;
  logic [DW-1:0] m_mem [32];
  logic [DW-1:0] exp_c_q[$];
  logic [DW-1:0] exp_d_q[$];
  logic [DW-1:0] hold_c, hold_d;

  function automatic logic [1:0] pred_gnt();
    if (!reset_n) return 2'b00;
    if (m_owner == 1) return {1'b0, c_req};
    if (m_owner == 2) return {d_req, 1'b0};
    if (c_req && d_req) return (m_last == 1) ? 2'b01 : 2'b10;
    return {d_req, c_req};
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_owner <= 0;
      m_beats <= 0;
      m_last  <= 1;
      exp_c_q.delete();
      exp_d_q.delete();
    end else begin
      if (pred_gnt() == 2'b01) begin
        if (c_we) m_mem[c_addr] <= c_wdata;
        else exp_c_q.push_back(m_mem[c_addr]);
      end
      if (pred_gnt() == 2'b10) begin
        if (d_we) m_mem[d_addr] <= d_wdata;
        else exp_d_q.push_back(m_mem[d_addr]);
      end
      if (m_owner == 0) begin
        if (pred_gnt() != 2'b00) begin
          m_last <= pred_gnt()[1] ? 1 : 0;
          if ((pred_gnt()[1] ? d_lock : c_lock) && MAX_BURST > 1) begin
            m_owner <= pred_gnt()[1] ? 2 : 1;
            m_beats <= 1;
          end
        end
      end else begin
        if (!(m_owner == 1 ? c_req : d_req) || !(m_owner == 1 ? c_lock : d_lock) ||
            m_beats + 1 >= MAX_BURST) begin
          m_owner <= 0;
          m_beats <= 0;
        end else begin
          m_beats <= m_beats + 1;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  task automatic compare();
    logic [1:0]    g;
    logic          evc, evd;
    g = pred_gnt();
    chk("c_gnt", 32'(c_gnt), 32'(g[0]));
    chk("d_gnt", 32'(d_gnt), 32'(g[1]));
    chk("c_stall", 32'(c_stall), 32'(c_req & ~g[0]));
    chk("mem_we", 32'(mem_we), 32'((g[0] & c_we) | (g[1] & d_we)));
    chk("mem_re", 32'(mem_re), 32'((g[0] & ~c_we) | (g[1] & ~d_we)));
    chk("mem_addr", 32'(mem_addr), g[0] ? 32'(c_addr) : (g[1] ? 32'(d_addr) : 32'd0));
    chk("mem_wdata", mem_wdata, g[0] ? c_wdata : (g[1] ? d_wdata : 32'd0));
    if (!reset_n) begin
      hold_c = '0;
      hold_d = '0;
      evc    = 1'b0;
      evd    = 1'b0;
    end else begin
      evc = (exp_c_q.size() != 0);
      evd = (exp_d_q.size() != 0);
      if (evc) hold_c = exp_c_q.pop_front();
      if (evd) hold_d = exp_d_q.pop_front();
    end
    chk("c_rvalid", 32'(c_rvalid), 32'(evc));
    chk("c_rdata", c_rdata, hold_c);
    chk("d_rvalid", 32'(d_rvalid), 32'(evd));
    chk("d_rdata", d_rdata, hold_d);
  endtask

  always @(negedge clk) if (run) compare();

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic drive_c(input logic req, input logic we, input logic lock,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    c_req = req; c_we = we; c_lock = lock; c_addr = addr; c_wdata = wdata;
  endtask

  task automatic drive_d(input logic req, input logic we, input logic lock,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    d_req = req; d_we = we; d_lock = lock; d_addr = addr; d_wdata = wdata;
  endtask

  // ---------------- stimulus ----------------
  logic [1:0] alt_c [4];
  logic [5:0] burst_d;

  initial begin
    hold_c  = '0;
    hold_d  = '0;
    reset_n = 1'b0;
    drive_c(0, 0, 0, '0, '0);
    drive_d(0, 0, 0, '0, '0);
    run = 1'b1;

    // reset state
    repeat (2) next_cycle();
    sample();
    chk("rst_c_gnt", 32'(c_gnt), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_c_rvalid", 32'(c_rvalid), 32'd0);
    chk("rst_c_rdata", c_rdata, 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));

    next_cycle();
    reset_n = 1'b1;

    // preload every word through port C so model and memory agree
    for (int a = 0; a < 32; a++) begin
      next_cycle();
      drive_c(1, 1, 0, AW'(a), $urandom());
    end

    // write then read address 3
    next_cycle();
    drive_c(1, 1, 0, 5'd3, 32'hDEADBEEF);
    sample();
    chk("wr_c_gnt", 32'(c_gnt), 32'd1);
    chk("wr_mem_we", 32'(mem_we), 32'd1);
    chk("wr_mem_addr", 32'(mem_addr), 32'd3);
    next_cycle();
    drive_c(1, 0, 0, 5'd3, '0);
    sample();
    chk("rd_c_stall", 32'(c_stall), 32'd0);
    chk("rd_mem_re", 32'(mem_re), 32'd1);
    next_cycle();
    drive_c(0, 0, 0, '0, '0);
    sample();
    chk("rd_c_rvalid", 32'(c_rvalid), 32'd1);
    chk("rd_c_rdata", c_rdata, 32'hDEADBEEF);
    chk("rd_c_stall_after", 32'(c_stall), 32'd0);

    // D beat makes D the last owner, then a four-cycle tie alternates C,D,C,D
    next_cycle();
    drive_d(1, 1, 0, 5'd7, 32'h0000_1234);
    sample();
    chk("d_only_gnt", 32'(d_gnt), 32'd1);
    alt_c[0] = 2'b01; alt_c[1] = 2'b10; alt_c[2] = 2'b01; alt_c[3] = 2'b10;
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      drive_c(1, 0, 0, 5'd3, '0);
      drive_d(1, 0, 0, 5'd7, '0);
      sample();
      chk("alt_gnt", {30'd0, d_gnt, c_gnt}, 32'(alt_c[i]));
      chk("alt_stall", 32'(c_stall), 32'(alt_c[i][1]));
    end

    // C beat makes C the last owner; D then locks for a full burst
    next_cycle();
    drive_c(1, 1, 0, 5'd9, 32'hCAFE_0009);
    drive_d(0, 0, 0, '0, '0);
    burst_d = 6'b101111;
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      drive_c(1, 0, 0, 5'd9, '0);
      drive_d(1, 1, 1, AW'(16 + i), 32'h0D00_0000 + 32'(i));
      sample();
      chk("burst_d_gnt", 32'(d_gnt), 32'(burst_d[i]));
      chk("burst_c_stall", 32'(c_stall), 32'(burst_d[i]));
    end

    // D's second burst: beat 2 without C, then D drops req -> bubble -> C
    next_cycle();
    drive_c(0, 0, 0, '0, '0);
    sample();
    chk("drop_beat2", 32'(d_gnt), 32'd1);
    next_cycle();
    drive_c(1, 1, 0, 5'd12, 32'h1111_2222);
    drive_d(0, 0, 0, '0, '0);
    sample();
    chk("drop_bubble", {30'd0, d_gnt, c_gnt}, 32'd0);
    chk("drop_bubble_stall", 32'(c_stall), 32'd1);
    next_cycle();
    sample();
    chk("drop_then_c", 32'(c_gnt), 32'd1);

    // reset pulse in the middle of a locked read burst
    next_cycle();
    drive_c(1, 0, 1, 5'd3, '0);
    next_cycle();
    #3 reset_n = 1'b0;
    #2;
    #1 reset_n = 1'b1;
    drive_c(0, 0, 0, '0, '0);
    next_cycle();
    sample();
    chk("rst_mid_rvalid", 32'(c_rvalid), 32'd0);
    chk("rst_mid_state", 32'(dbg_state), 32'(IDLE));
    next_cycle();
    drive_c(1, 0, 0, 5'd1, '0);
    drive_d(1, 0, 0, 5'd2, '0);
    sample();
    chk("rst_mid_tie_c", 32'(c_gnt), 32'd1);

    // randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      next_cycle();
      reset_n = ($urandom_range(0, 149) != 0);
      drive_c($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
              AW'($urandom_range(0, 31)), $urandom());
      drive_d($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0,
              AW'($urandom_range(0, 31)), $urandom());
    end
    next_cycle();
    reset_n = 1'b1;
    drive_c(0, 0, 0, '0, '0);
    drive_d(0, 0, 0, '0, '0);
    repeat (3) next_cycle();
    sample();
    run = 1'b0;

    // ---------------- final report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
